// File: rtl/ipb_io_arb_pkg.sv
// Shared types and constants for the IPbus register-I/O arbiter.
// Optional read timeout is enabled with IPB_IO_ARB_TIMEOUT_EN.
package ipb_io_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ_START,
    ST_READ_WAIT,
    ST_READ_DLY1,
    ST_READ_DLY2,
    ST_READ_ACK,
    ST_WRITE_START,
    ST_WRITE_ENABLE,
    ST_WRITE_ACK,
    ST_ERR_ACK
  } state_e;

  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int TIMEOUT_CNT_W      = $clog2(DEF_TIMEOUT_CYCLES + 1);

  // Read data returned on a timed-out read; sliced to DATA_W by the user.
  localparam int                    MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] ERR_RDATA  = '1;

  // Counter width for a non-default TIMEOUT_CYCLES override.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/ipb_io_arbiter_rr.sv
// Combinational round-robin pick: first unmasked request at or after the
// pointer, scanning upward with wrap-around.
module ipb_rr_arbiter
  import ipb_io_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_mask_vld,
  input  logic [IDX_W-1:0] i_mask_id,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);

  logic [N_REQ-1:0] w_cand;
  logic [IDX_W:0]   w_pos;

  // drop the requester that was just acked so a lingering strobe is not re-served
  always_comb begin
    w_cand = i_req;
    if (i_mask_vld) w_cand[i_mask_id] = 1'b0;
  end

  // scan from the pointer upward, first hit wins
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    w_pos = '0;
    for (int off = 0; off < N_REQ; off++) begin
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(off);
      if (w_pos >= (IDX_W+1)'(N_REQ)) w_pos = w_pos - (IDX_W+1)'(N_REQ);
      if (!o_vld && w_cand[w_pos[IDX_W-1:0]]) begin
        o_vld = 1'b1;
        o_idx = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ipb_io_arbiter.sv
// Shares one register-I/O port between N_REQ IPbus-style requesters.
// Level read enable, one-cycle write enable, ack/err/rdata routed back to
// the granted requester. Define IPB_IO_ARB_TIMEOUT_EN to bound READ_WAIT.
module ipb_io_arbiter
  import ipb_io_arb_pkg::*;
#(
  parameter  int N_REQ          = 2,
  parameter  int ADDR_W         = 16,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int ID_W           = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic [N_REQ-1:0]         req_strobe,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ack,
  output logic [N_REQ-1:0]         req_err,
  output logic [DATA_W-1:0]        req_rdata,
  output logic [ID_W-1:0]          grant_id,
  output logic [ADDR_W-1:0]        io_addr,
  output logic [DATA_W-1:0]        io_wdata,
  output logic                     io_rd_en,
  output logic                     io_wr_en,
  output logic                     io_sync,
  input  logic                     io_rd_ack,
  input  logic [DATA_W-1:0]        io_rdata
);

  state_e            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_ptr, r_grant_id, r_mask_id;
  logic              r_mask_vld;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_arb_vld, w_grant, w_timeout, w_done, w_err;
  logic [ID_W-1:0]   w_arb_idx;

  ipb_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req      (req_strobe),
    .i_ptr      (r_ptr),
    .i_mask_vld (r_mask_vld),
    .i_mask_id  (r_mask_id),
    .o_vld      (w_arb_vld),
    .o_idx      (w_arb_idx)
  );

  assign w_grant = (r_state == ST_IDLE) && w_arb_vld;

`ifdef IPB_IO_ARB_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_tmo_cnt;

  // count cycles spent in READ_WAIT; any other state restarts the count
  always_ff @(posedge clk) begin
    if (!res_n)                       r_tmo_cnt <= '0;
    else if (r_state == ST_READ_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    else                              r_tmo_cnt <= '0;
  end

  assign w_timeout = (r_state == ST_READ_WAIT) && !io_rd_ack &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_timeout    = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!res_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state and port strobes decoded from the current state
  always_comb begin
    w_state_nxt = r_state;
    io_rd_en    = 1'b0;
    io_wr_en    = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE:
        if (w_arb_vld) w_state_nxt = req_write[w_arb_idx] ? ST_WRITE_START : ST_READ_START;
      ST_READ_START: begin
        io_rd_en    = 1'b1;
        w_state_nxt = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        io_rd_en = 1'b1;
        if (io_rd_ack)      w_state_nxt = ST_READ_DLY1;
        else if (w_timeout) w_state_nxt = ST_ERR_ACK;
      end
      ST_READ_DLY1: begin
        io_rd_en    = 1'b1;
        w_state_nxt = ST_READ_DLY2;
      end
      ST_READ_DLY2: begin
        io_rd_en    = 1'b1;
        w_state_nxt = ST_READ_ACK;
      end
      ST_READ_ACK: begin
        io_rd_en    = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_WRITE_START:  w_state_nxt = ST_WRITE_ENABLE;
      ST_WRITE_ENABLE: begin
        io_wr_en    = 1'b1;
        w_state_nxt = ST_WRITE_ACK;
      end
      ST_WRITE_ACK: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR_ACK: begin
        w_err       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // grant latch, RR pointer, re-grant mask and read-data return register
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_mask_vld <= 1'b0;
      r_mask_id  <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_mask_vld <= w_done | w_err;
      r_mask_id  <= r_grant_id;
      if (w_grant) begin
        r_grant_id <= w_arb_idx;
        r_addr     <= req_addr[w_arb_idx*ADDR_W +: ADDR_W];
        r_wdata    <= req_wdata[w_arb_idx*DATA_W +: DATA_W];
        r_ptr      <= (w_arb_idx == ID_W'(N_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
      end
      if (r_state == ST_READ_DLY2) r_rdata <= io_rdata;
      else if (w_timeout)          r_rdata <= ERR_RDATA[DATA_W-1:0];
    end
  end

  assign req_ack   = w_done ? (N_REQ'(1) << r_grant_id) : '0;
  assign req_err   = w_err  ? (N_REQ'(1) << r_grant_id) : '0;
  assign req_rdata = r_rdata;
  assign grant_id  = r_grant_id;
  assign io_addr   = r_addr;
  assign io_wdata  = r_wdata;
  assign io_sync   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ipb_io_arbiter.sv
// Scoreboard bench for ipb_io_arbiter: stimulus pushes expected responses
// and writes, negedge monitors pop and compare. IPB_IO_ARB_TIMEOUT_EN
// selects which timeout scenario runs.
module tb_ipb_io_arbiter;
  localparam int N_REQ  = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic                    clk = 1'b0;
  logic                    res_n = 1'b0;
  logic [N_REQ-1:0]        req_strobe = '0;
  logic [N_REQ-1:0]        req_write = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ*DATA_W-1:0] req_wdata = '0;
  logic [N_REQ-1:0]        req_ack, req_err;
  logic [DATA_W-1:0]       req_rdata;
  logic [0:0]              grant_id;
  logic [ADDR_W-1:0]       io_addr;
  logic [DATA_W-1:0]       io_wdata;
  logic                    io_rd_en, io_wr_en, io_sync;
  logic                    io_rd_ack = 1'b0;
  logic [DATA_W-1:0]       io_rdata = 32'hBAD0BAD0;

  ipb_io_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .res_n(res_n), .req_strobe(req_strobe), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack), .req_err(req_err),
    .req_rdata(req_rdata), .grant_id(grant_id), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rd_en(io_rd_en), .io_wr_en(io_wr_en), .io_sync(io_sync),
    .io_rd_ack(io_rd_ack), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int id; bit err; logic [DATA_W-1:0] rdata; bit chk; } exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  int tests = 0, fails = 0, cyc = 0;
  int ack_total = 0, wr_cnt = 0, wr_cyc = -1, err_cyc = -1;
  int ack_cnt[N_REQ] = '{default:0};
  int ack_cyc[N_REQ] = '{default:-1};

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // response monitor: every ack/err pops one expectation
  always @(negedge clk) begin
    int   id;
    exp_t e;
    if ((|req_ack) || (|req_err)) begin
      id = -1;
      for (int i = 0; i < N_REQ; i++) if (req_ack[i] || req_err[i]) id = i;
      check("resp_onehot", 64'($countones({req_ack, req_err})), 64'd1);
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'(id), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("resp_id", 64'(id), 64'(e.id));
        check("resp_is_err", 64'(|req_err), 64'(e.err));
        if (e.chk) check("resp_rdata", 64'(req_rdata), 64'(e.rdata));
      end
      if (|req_ack) begin ack_cnt[id]++; ack_cyc[id] = cyc; end
      if (|req_err) err_cyc = cyc;
      ack_total++;
    end
  end

  // write monitor: every io_wr_en pulse pops one expected write
  always @(negedge clk) begin
    wr_t w;
    if (io_wr_en === 1'b1) begin
      wr_cnt++;
      wr_cyc = cyc;
      if (wr_q.size() == 0) begin
        check("wr_unexpected", 64'(io_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", 64'(io_addr), 64'(w.addr));
        check("wr_data", 64'(io_wdata), 64'(w.data));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input bit err, input logic [DATA_W-1:0] rd, input bit chk);
    exp_t e;
    e.id = id; e.err = err; e.rdata = rd; e.chk = chk;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic set_req(input int i, input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_write[i] = wr;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_strobe[i] = 1'b1;
  endtask

  task automatic wait_resp(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (ack_total < target && n < budget) begin step(); n++; end
    tests++;
    if (ack_total < target) begin
      fails++;
      $display("FAIL %s: got %0d responses expected %0d within %0d cycles", nm, ack_total, target, budget);
    end
  endtask

  initial begin
    int g, base, bad, a0, a1, w0;

    // reset state
    repeat (3) step();
    check("rst_io_sync", 64'(io_sync), 0);
    check("rst_io_rd_en", 64'(io_rd_en), 0);
    check("rst_io_wr_en", 64'(io_wr_en), 0);
    check("rst_req_ack", 64'(req_ack), 0);
    check("rst_req_err", 64'(req_err), 0);
    check("rst_grant_id", 64'(grant_id), 0);
    check("rst_io_addr", 64'(io_addr), 0);
    check("rst_req_rdata", 64'(req_rdata), 0);
    res_n = 1'b1;
    step();

    // single write; strobe lingers one cycle after the ack
    g = cyc; w0 = wr_cnt;
    set_req(0, 1'b1, 16'h0010, 32'hA5A5A5A5);
    push_exp(0, 1'b0, '0, 1'b0);
    push_wr(16'h0010, 32'hA5A5A5A5);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 5) begin
        check("wr_no_regrant_sync", 64'(io_sync), 0);
        req_strobe[0] = 1'b0;
      end
    end
    check("wr_en_cycle", 64'(wr_cyc), 64'(g + 2));
    check("wr_ack_cycle", 64'(ack_cyc[0]), 64'(g + 3));
    check("wr_single_pulse", 64'(wr_cnt - w0), 1);

    // single read from req1
    g = cyc; bad = 0;
    set_req(1, 1'b0, 16'h0020, '0);
    push_exp(1, 1'b0, 32'h12345678, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (io_rd_en !== ((k <= 7) ? 1'b1 : 1'b0)) bad++;
      if (k == 4) begin io_rd_ack = 1'b1; io_rdata = 32'h12345678; end
      if (k == 5) io_rd_ack = 1'b0;
      if (k == 7) begin req_strobe[1] = 1'b0; io_rdata = 32'hBAD0BAD0; end
    end
    check("rd_en_window_bad", 64'(bad), 0);
    check("rd_ack_cycle", 64'(ack_cyc[1]), 64'(g + 7));
    check("rd_rdata_hold", 64'(req_rdata), 64'h12345678);
    check("rd_grant_id", 64'(grant_id), 1);
    check("rd_addr_hold", 64'(io_addr), 64'h0020);

    // contention: both write continuously, grants alternate 0,1,0,1
    base = ack_total; a0 = ack_cnt[0]; a1 = ack_cnt[1];
    set_req(0, 1'b1, 16'h0100, 32'h11110000);
    set_req(1, 1'b1, 16'h0200, 32'h22220000);
    for (int k = 0; k < 2; k++) begin
      push_exp(0, 1'b0, '0, 1'b0); push_wr(16'h0100, 32'h11110000);
      push_exp(1, 1'b0, '0, 1'b0); push_wr(16'h0200, 32'h22220000);
    end
    wait_resp(base + 4, 60, "cont_done");
    req_strobe = '0;
    check("cont_ack0", 64'(ack_cnt[0] - a0), 2);
    check("cont_ack1", 64'(ack_cnt[1] - a1), 2);
    repeat (4) step();

    // strobe drop during WRITE_ENABLE; pending req1 served next
    g = cyc; base = ack_total;
    set_req(0, 1'b1, 16'h0030, 32'hDEADBEEF);
    set_req(1, 1'b1, 16'h0040, 32'hCAFEF00D);
    push_exp(0, 1'b0, '0, 1'b0); push_wr(16'h0030, 32'hDEADBEEF);
    push_exp(1, 1'b0, '0, 1'b0); push_wr(16'h0040, 32'hCAFEF00D);
    step(); step();
    req_strobe[0] = 1'b0;
    wait_resp(base + 2, 30, "drop_done");
    req_strobe[1] = 1'b0;
    check("drop_ack0_cycle", 64'(ack_cyc[0]), 64'(g + 3));
    check("drop_ack1_cycle", 64'(ack_cyc[1]), 64'(g + 7));
    check("drop_wr1_cycle", 64'(wr_cyc), 64'(g + 6));
    repeat (3) step();

    // reset mid-read on req0 (moves RR pointer to 1), then pointer back to 0
    base = ack_total;
    set_req(0, 1'b0, 16'h0050, '0);
    step(); step();
    check("rstmid_rd_en_before", 64'(io_rd_en), 1);
    res_n = 1'b0;
    step();
    check("rstmid_rd_en", 64'(io_rd_en), 0);
    check("rstmid_sync", 64'(io_sync), 0);
    check("rstmid_ack", 64'(req_ack), 0);
    check("rstmid_addr", 64'(io_addr), 0);
    req_strobe = '0;
    step();
    res_n = 1'b1;
    repeat (3) step();
    check("rstmid_no_resp", 64'(ack_total), 64'(base));
    set_req(0, 1'b1, 16'h0060, 32'h60606060);
    set_req(1, 1'b1, 16'h0070, 32'h70707070);
    push_exp(0, 1'b0, '0, 1'b0); push_wr(16'h0060, 32'h60606060);
    push_exp(1, 1'b0, '0, 1'b0); push_wr(16'h0070, 32'h70707070);
    step();
    check("rstmid_first_grant", 64'(grant_id), 0);
    wait_resp(base + 2, 30, "rstmid_done");
    req_strobe = '0;
    repeat (3) step();

`ifdef IPB_IO_ARB_TIMEOUT_EN
    // read with no io_rd_ack: error after TMO cycles of READ_WAIT
    g = cyc; base = ack_total; a0 = ack_cnt[0];
    io_rdata = 32'h0BADF00D;
    set_req(0, 1'b0, 16'h0080, '0);
    push_exp(0, 1'b1, 32'hFFFFFFFF, 1'b1);
    wait_resp(base + 1, 40, "tmo_done");
    check("tmo_rd_en_in_err", 64'(io_rd_en), 0);
    req_strobe = '0;
    check("tmo_err_cycle", 64'(err_cyc), 64'(g + 2 + TMO));
    check("tmo_no_ack", 64'(ack_cnt[0] - a0), 0);
    repeat (3) step();
    check("tmo_rdata_hold", 64'(req_rdata), 64'hFFFFFFFF);
`else
    // read with no io_rd_ack: parks in READ_WAIT, then completes late
    base = ack_total; bad = 0;
    set_req(0, 1'b0, 16'h0080, '0);
    repeat (2) step();
    for (int k = 0; k < 1000; k++) begin
      step();
      if (io_rd_en !== 1'b1 || req_ack !== '0 || req_err !== '0) bad++;
    end
    check("nt_wait_bad", 64'(bad), 0);
    check("nt_sync", 64'(io_sync), 1);
    io_rdata = 32'h55AA55AA;
    push_exp(0, 1'b0, 32'h55AA55AA, 1'b1);
    io_rd_ack = 1'b1;
    step();
    io_rd_ack = 1'b0;
    wait_resp(base + 1, 20, "nt_done");
    req_strobe = '0;
    repeat (3) step();
`endif

    check("exp_q_drained", 64'(exp_q.size()), 0);
    check("wr_q_drained", 64'(wr_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
